// File: rtl/interrupt_control_pkg.sv
// Shared cpu6502 definitions: interrupt FSM encodings, vector low bytes and
// processor-status bit positions (also used by the status register).
package interrupt_control_pkg;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_IDLE  = 3'd1,
    S_NMI   = 3'd2,
    S_IRQ   = 3'd3,
    S_BRK   = 3'd4
  } state_e;

  localparam logic [7:0] VEC_NMI   = 8'hFA;
  localparam logic [7:0] VEC_RESET = 8'hFC;
  localparam logic [7:0] VEC_IRQ   = 8'hFE;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_V = 6;
  localparam int P_N = 7;

  function automatic logic is_seq(input state_e s);
    return (s == S_NMI) || (s == S_IRQ) || (s == S_BRK);
  endfunction

endpackage

// File: rtl/interrupt_control_if.sv
// Signal bundle between the interrupt sequencer and the rest of the cpu6502 core.
interface interrupt_control_if;

  logic       i_nmi_n;
  logic       i_irq_n;
  logic       i_p_i;
  logic       i_sync;
  logic       i_brk;
  logic       i_vector_fetch;
  logic       i_vector_done;
  logic       o_force_brk;
  logic       o_int_active;
  logic [7:0] o_vector_lo;
  logic       o_b;
  logic       o_set_i;
  logic       o_suppress_write;

  modport slave (
    input  i_nmi_n, i_irq_n, i_p_i, i_sync, i_brk, i_vector_fetch, i_vector_done,
    output o_force_brk, o_int_active, o_vector_lo, o_b, o_set_i, o_suppress_write
  );

  modport master (
    output i_nmi_n, i_irq_n, i_p_i, i_sync, i_brk, i_vector_fetch, i_vector_done,
    input  o_force_brk, o_int_active, o_vector_lo, o_b, o_set_i, o_suppress_write
  );

endinterface

// File: rtl/interrupt_control_nmi_edge_detect.sv
// NMI pin synchroniser and falling-edge latch; a new edge beats a clear
// arriving in the same cycle so no NMI is ever lost.
module interrupt_control_nmi_edge_detect #(
  parameter int SYNC_STAGES = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_nmi_n,
  input  logic i_clr,
  output logic o_latch
);

  logic nmi_cur;
  logic prev_q;
  logic latch_q;
  logic latch_d;
  logic edge_det;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign nmi_cur = i_nmi_n;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          sync_q <= '1;
        end else begin
          sync_q[0] <= i_nmi_n;
          for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end
      assign nmi_cur = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign edge_det = prev_q & ~nmi_cur;
  assign latch_d  = edge_det | (latch_q & ~i_clr);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      prev_q  <= 1'b1;
      latch_q <= 1'b0;
    end else begin
      prev_q  <= nmi_cur;
      latch_q <= latch_d;
    end
  end

  assign o_latch = latch_q;

endmodule

// File: rtl/interrupt_control.sv
// cpu6502 interrupt sequencer: arbitrates reset/NMI/IRQ/BRK entry and drives
// the forced-BRK, vector select, B value and I-set strobe for the entry sequence.
module interrupt_control
  import interrupt_control_pkg::*;
#(
  parameter int SYNC_STAGES = 1
) (
  input logic                 i_clk,
  input logic                 i_reset,
  interrupt_control_if.slave  bus
);

  state_e state_q, state_d;
  logic   fetched_q, fetched_d;
  logic   hijack_q, hijack_d;
  logic   nmi_latch;
  logic   irq_cur;
  logic   irq_pend;
  logic   in_seq;
  logic   idle_eval;
  logic   take_nmi;
  logic   take_irq;
  logic   nmi_clr;
  logic   nmi_seen;

  generate
    if (SYNC_STAGES == 0) begin : g_irq_direct
      assign irq_cur = bus.i_irq_n;
    end else begin : g_irq_sync
      logic [SYNC_STAGES-1:0] irq_sync_q;
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          irq_sync_q <= '1;
        end else begin
          irq_sync_q[0] <= bus.i_irq_n;
          for (int k = 1; k < SYNC_STAGES; k++) irq_sync_q[k] <= irq_sync_q[k-1];
        end
      end
      assign irq_cur = irq_sync_q[SYNC_STAGES-1];
    end
  endgenerate

  interrupt_control_nmi_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_nmi (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_nmi_n (bus.i_nmi_n),
    .i_clr   (nmi_clr),
    .o_latch (nmi_latch)
  );

  assign irq_pend  = ~irq_cur & ~bus.i_p_i;
  assign in_seq    = is_seq(state_q);
  // A sequence ending this cycle hands the same i_sync to the idle arbiter.
  assign idle_eval = (state_q == S_IDLE) | (in_seq & bus.i_vector_done);
  assign take_nmi  = idle_eval & bus.i_sync & nmi_latch;
  assign take_irq  = idle_eval & bus.i_sync & irq_pend;
  assign nmi_clr   = in_seq & bus.i_vector_fetch;
  // NMI arriving before the vector is read redirects an IRQ/BRK sequence.
  assign nmi_seen  = nmi_latch & ~fetched_q & ((state_q == S_IRQ) | (state_q == S_BRK));

  always_comb begin
    state_d   = state_q;
    fetched_d = fetched_q;
    hijack_d  = hijack_q | nmi_seen;
    if (in_seq && bus.i_vector_fetch) fetched_d = 1'b1;
    if (idle_eval) begin
      state_d   = S_IDLE;
      fetched_d = 1'b0;
      hijack_d  = 1'b0;
      if (take_nmi)                                 state_d = S_NMI;
      else if (take_irq)                            state_d = S_IRQ;
      else if (state_q == S_IDLE && bus.i_brk)      state_d = S_BRK;
    end else if (state_q == S_RESET && bus.i_vector_done) begin
      state_d   = S_IDLE;
      fetched_d = 1'b0;
      hijack_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_RESET;
      fetched_q <= 1'b0;
      hijack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      fetched_q <= fetched_d;
      hijack_q  <= hijack_d;
    end
  end

  always_comb begin
    bus.o_force_brk      = take_nmi | take_irq;
    bus.o_int_active     = 1'b0;
    bus.o_vector_lo      = VEC_IRQ;
    bus.o_b              = 1'b1;
    bus.o_set_i          = 1'b0;
    bus.o_suppress_write = 1'b0;
    case (state_q)
      S_RESET: begin
        bus.o_force_brk      = 1'b1;
        bus.o_int_active     = 1'b1;
        bus.o_vector_lo      = VEC_RESET;
        bus.o_b              = 1'b0;
        bus.o_set_i          = bus.i_vector_fetch & ~i_reset;
        bus.o_suppress_write = 1'b1;
      end
      S_NMI: begin
        bus.o_force_brk  = 1'b1;
        bus.o_int_active = 1'b1;
        bus.o_vector_lo  = VEC_NMI;
        bus.o_b          = 1'b0;
        bus.o_set_i      = bus.i_vector_fetch;
      end
      S_IRQ: begin
        bus.o_force_brk  = 1'b1;
        bus.o_int_active = 1'b1;
        bus.o_vector_lo  = (hijack_q | nmi_seen) ? VEC_NMI : VEC_IRQ;
        bus.o_b          = 1'b0;
        bus.o_set_i      = bus.i_vector_fetch;
      end
      S_BRK: begin
        bus.o_int_active = 1'b1;
        bus.o_vector_lo  = (hijack_q | nmi_seen) ? VEC_NMI : VEC_IRQ;
        bus.o_b          = 1'b1;
        bus.o_set_i      = bus.i_vector_fetch;
      end
      default: ;
    endcase
  end

endmodule
